sram_like_ram_slave: RTL and testbench

//  Slave for the CPU's sram-like data/inst port (req/addr_ok/data_ok), downstream of mycpu_top.

---
 rtl/sram_like_ram_slave_if.sv | 22 ++
 rtl/sram_like_ram_slave.sv | 140 ++++++++++++++
 tb/tb_sram_like_ram_slave.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_ram_slave_if.sv
// CPU-side sram-like handshake bundle (req/addr_ok/data_ok) between the CPU master and the RAM slave.
interface sram_like_ram_slave_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_ram_slave.sv
// sram-like CPU port slave onto a 1-cycle synchronous RAM, in-order responses, up to DEPTH outstanding.
// Optional macro RAND_DELAY_EN enables LFSR-driven stall injection on addr_ok and data_ok.
module sram_like_ram_slave #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned RAM_AW    = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  sram_like_ram_slave_if.slave bus,
  output logic                ram_en,
  output logic [3:0]          ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [31:0]         ram_wdata,
  input  logic [31:0]         ram_rdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = $clog2(DEPTH + 2);

  logic              stall_acc;
  logic              stall_rsp;
  logic              acc;
  logic              push;
  logic              pop;

  logic              p1_valid_q, p1_valid_d;
  logic              p1_wr_q, p1_wr_d;

  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [OCC_W-1:0]  occupancy;
  logic [31:0]       push_data;

  // Stall generation: LFSR-driven when enabled, tied off otherwise.
`ifdef RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall_acc = lfsr_q[0] & lfsr_q[1];
  assign stall_rsp = lfsr_q[2] & lfsr_q[3];
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign stall_acc   = 1'b0;
  assign stall_rsp   = 1'b0;
`endif

  // Only the word address reaches the RAM; size is informational.
  logic unused_bits;
  assign unused_bits = ^{bus.size, bus.addr[1:0], bus.addr[31:RAM_AW+2]};

  assign pop  = (count_q != '0) & ~stall_rsp;
  assign push = p1_valid_q;

  // Accept only when the response slot is guaranteed; no path from req.
  assign occupancy   = OCC_W'(p1_valid_q) + OCC_W'(count_q) - OCC_W'(pop);
  assign bus.addr_ok = ~reset & ~stall_acc & (occupancy < OCC_W'(DEPTH));
  assign acc         = bus.req & bus.addr_ok;

  assign ram_en    = acc;
  assign ram_we    = (acc & bus.wr) ? bus.wstrb : 4'h0;
  assign ram_addr  = bus.addr[RAM_AW+1:2];
  assign ram_wdata = bus.wdata;

  assign bus.data_ok = pop;
  assign bus.rdata   = pop ? mem_q[rd_ptr_q] : 32'h0;

  assign push_data = p1_wr_q ? 32'h0 : ram_rdata;

  always_comb begin
    p1_valid_d = acc;
    p1_wr_d    = acc & bus.wr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_valid_q <= 1'b0;
      p1_wr_q    <= 1'b0;
    end else begin
      p1_valid_q <= p1_valid_d;
      p1_wr_q    <= p1_wr_d;
    end
  end

  // Pointer/count next state; pointers wrap at DEPTH-1 so DEPTH=1 stays at zero.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Response storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_sram_like_ram_slave.sv
// Randomized scoreboard bench for sram_like_ram_slave (DEPTH=2 main instance, DEPTH=1 throughput instance).
module tb_sram_like_ram_slave;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_like_ram_slave_if bus0 ();
  sram_like_ram_slave_if bus1 ();

  logic        ram_en0, ram_en1;
  logic [3:0]  ram_we0, ram_we1;
  logic [15:0] ram_addr0, ram_addr1;
  logic [31:0] ram_wdata0, ram_wdata1;
  logic [31:0] ram_rdata0, ram_rdata1;

  sram_like_ram_slave #(.DEPTH(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0),
    .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
  );

  sram_like_ram_slave #(.DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
  );

  // Synchronous RAMs with one-cycle read latency.
  bit [31:0] ram0 [0:65535];
  always @(posedge clk) begin
    if (ram_en0) begin
      for (int b = 0; b < 4; b++)
        if (ram_we0[b]) ram0[ram_addr0][b*8 +: 8] <= ram_wdata0[b*8 +: 8];
      if (ram_we0 == 4'h0) ram_rdata0 <= ram0[ram_addr0];
    end
  end

  always @(posedge clk) begin
    if (ram_en1) ram_rdata1 <= {16'h5A5A, ram_addr1};
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t      sbq[$];
  exp_t      mon_e;
  bit [31:0] ref_mem [0:65535];
  int        checks = 0;
  int        errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every data_ok pops the oldest expected response.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus0.data_ok) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_data_ok: got data_ok=1 with nothing outstanding, expected 0 (cycle %0d)", cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("rdata", bus0.rdata, mon_e.data);
`ifndef RAND_DELAY_EN
          chk("latency_cycle", cyc, mon_e.due);
`endif
        end
      end else begin
        chk("rdata_idle", bus0.rdata, 32'h0);
      end
    end
  end

  // Drive one request from a negedge; returns at the negedge after it is accepted.
  task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output int waits);
    bit   done;
    exp_t e;
    int   word;
    bus0.req   = 1'b1;
    bus0.wr    = w;
    bus0.size  = 2'd2;
    bus0.addr  = a;
    bus0.wstrb = s;
    bus0.wdata = d;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      #1;
      if (bus0.addr_ok) begin
        word = int'(a[17:2]);
        chk("ram_en", 32'(ram_en0), 32'h1);
        chk("ram_addr", 32'(ram_addr0), 32'(a[17:2]));
        chk("ram_we", 32'(ram_we0), w ? 32'(s) : 32'h0);
        if (w) begin
          chk("ram_wdata", ram_wdata0, d);
          for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[word][b*8 +: 8] = d[b*8 +: 8];
          e.data = 32'h0;
        end else begin
          e.data = ref_mem[word];
        end
        e.due = cyc + 2;
        sbq.push_back(e);
        done = 1'b1;
      end else begin
        chk("ram_en_blocked", 32'(ram_en0), 32'h0);
      end
      @(negedge clk);
      if (!done) begin
        waits++;
        if (waits > 200) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: got no addr_ok in 200 cycles, expected acceptance");
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    bus0.req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    bus0.req = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, 32'(sbq.size()), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int total;
    int acc1;
    int dok1;
    bus0.req = 1'b1; bus0.wr = 1'b1; bus0.size = 2'd2; bus0.addr = 32'h10;
    bus0.wstrb = 4'hF; bus0.wdata = 32'h0;
    bus1.req = 1'b0; bus1.wr = 1'b0; bus1.size = 2'd2; bus1.addr = 32'h0;
    bus1.wstrb = 4'h0; bus1.wdata = 32'h0;
    ram_rdata0 = 32'h0;
    ram_rdata1 = 32'h0;
    reset = 1'b1;

    // Reset holds every output low even with a request pending.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_addr_ok", 32'(bus0.addr_ok), 32'h0);
    chk("rst_data_ok", 32'(bus0.data_ok), 32'h0);
    chk("rst_rdata", bus0.rdata, 32'h0);
    chk("rst_ram_en", 32'(ram_en0), 32'h0);
    chk("rst_ram_we", 32'(ram_we0), 32'h0);
    @(negedge clk);
    bus0.req = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Full-word write then read back.
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, w);
    issue(1'b0, 32'h10, 4'h0, 32'h0, w);
    drain("drain_t1");

    // Byte-lane merge.
    issue(1'b1, 32'h20, 4'hF, 32'h11223344, w);
    issue(1'b1, 32'h20, 4'b0010, 32'h0000AB00, w);
    issue(1'b0, 32'h20, 4'h0, 32'h0, w);
    drain("drain_t2");

    // Back-to-back reads of distinct words.
    for (int i = 0; i < 8; i++) issue(1'b1, 32'(i * 4), 4'hF, 32'hA5000000 | 32'(i), w);
    total = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 32'(i * 4), 4'h0, 32'h0, w);
      total += w;
    end
`ifndef RAND_DELAY_EN
    chk("b2b_wait_cycles", 32'(total), 32'h0);
`endif
    drain("drain_t3");

    // Reset with responses outstanding.
    issue(1'b0, 32'h10, 4'h0, 32'h0, w);
    issue(1'b0, 32'h20, 4'h0, 32'h0, w);
    bus0.req = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_data_ok", 32'(bus0.data_ok), 32'h0);
    chk("midrst_addr_ok", 32'(bus0.addr_ok), 32'h0);
    sbq.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    idle_cycles(4);
    issue(1'b0, 32'h10, 4'h0, 32'h0, w);
    drain("drain_t5");

    // Randomized traffic against the reference memory.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycles(1);
      issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)) << 2,
            4'($urandom_range(0, 15)), $urandom, w);
    end
    drain("drain_random");

    // DEPTH=1: one request every other cycle.
    acc1 = 0;
    dok1 = 0;
    bus1.req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
`ifndef RAND_DELAY_EN
      chk("d1_addr_ok", 32'(bus1.addr_ok), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("d1_data_ok", 32'(bus1.data_ok), (i >= 2 && i % 2 == 0) ? 32'h1 : 32'h0);
`endif
      if (bus1.addr_ok) acc1++;
      if (bus1.data_ok) dok1++;
      @(negedge clk);
    end
    bus1.req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus1.data_ok) dok1++;
      @(negedge clk);
    end
    chk("d1_resp_count", 32'(dok1), 32'(acc1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
